// File: rtl/ieee_to_int.sv
// IEEE-754 single precision to signed integer converter: truncates toward zero,
// saturates on overflow/NaN/inf, and runs one conversion at a time over valid/ready.
module ieee_to_int #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam int              MAG_W   = OUT_W + 24;
  localparam logic [7:0]      SAT_EXP = 8'(126 + OUT_W);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [MAG_W-1:0]   mag_r, mag_nxt_s;
  logic [4:0]         cnt_r, cnt_nxt_s;
  logic               left_r, left_nxt_s;
  logic               sticky_r, sticky_nxt_s;
  logic               sign_r, sign_nxt_s;
  logic [OUT_W-1:0]   out_data_r, out_data_nxt_s;
  logic               out_invalid_r, out_invalid_nxt_s;
  logic               out_inexact_r, out_inexact_nxt_s;
  logic               out_valid_r;
  logic [7:0]         diff_s;

  logic               in_sign_s;
  logic [7:0]         exp_s;
  logic [22:0]        frac_s;

  assign in_sign_s = in_data[31];
  assign exp_s     = in_data[30:23];
  assign frac_s    = in_data[22:0];

  // Next-state and datapath decode for the conversion FSM.
  always_comb begin
    state_nxt_s       = state_r;
    mag_nxt_s         = mag_r;
    cnt_nxt_s         = cnt_r;
    left_nxt_s        = left_r;
    sticky_nxt_s      = sticky_r;
    sign_nxt_s        = sign_r;
    out_data_nxt_s    = out_data_r;
    out_invalid_nxt_s = out_invalid_r;
    out_inexact_nxt_s = out_inexact_r;
    diff_s            = 8'd0;

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (exp_s == 8'hFF) begin
            state_nxt_s       = DONE;
            out_data_nxt_s    = ((frac_s != 23'd0) || in_sign_s) ? MIN_NEG : MAX_POS;
            out_invalid_nxt_s = 1'b1;
            out_inexact_nxt_s = 1'b0;
          end else if (exp_s >= SAT_EXP) begin
            state_nxt_s       = DONE;
            out_inexact_nxt_s = 1'b0;
            // -2^(OUT_W-1) exactly is representable and is not an overflow
            if (in_sign_s && (exp_s == SAT_EXP) && (frac_s == 23'd0)) begin
              out_data_nxt_s    = MIN_NEG;
              out_invalid_nxt_s = 1'b0;
            end else begin
              out_data_nxt_s    = in_sign_s ? MIN_NEG : MAX_POS;
              out_invalid_nxt_s = 1'b1;
            end
          end else if (exp_s < 8'd127) begin
            state_nxt_s       = DONE;
            out_data_nxt_s    = {OUT_W{1'b0}};
            out_invalid_nxt_s = 1'b0;
            out_inexact_nxt_s = (exp_s != 8'd0) || (frac_s != 23'd0);
          end else begin
            mag_nxt_s    = {{OUT_W{1'b0}}, 1'b1, frac_s};
            sticky_nxt_s = 1'b0;
            sign_nxt_s   = in_sign_s;
            // Binary point sits 23 bits above bit 0 of the loaded significand
            if (exp_s > 8'd150) begin
              left_nxt_s = 1'b1;
              diff_s     = exp_s - 8'd150;
            end else begin
              left_nxt_s = 1'b0;
              diff_s     = 8'd150 - exp_s;
            end
            cnt_nxt_s   = diff_s[4:0];
            state_nxt_s = (diff_s == 8'd0) ? SIGN : SHIFT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SHIFT: begin
        if (left_r) begin
          mag_nxt_s = mag_r << 1;
        end else begin
          mag_nxt_s    = mag_r >> 1;
          sticky_nxt_s = sticky_r | mag_r[0];
        end
        cnt_nxt_s = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_nxt_s = SIGN;
        end else begin
          state_nxt_s = SHIFT;
        end
      end

      SIGN: begin
        if (sign_r) begin
          out_data_nxt_s = {OUT_W{1'b0}} - mag_r[OUT_W-1:0];
        end else begin
          out_data_nxt_s = mag_r[OUT_W-1:0];
        end
        out_inexact_nxt_s = sticky_r;
        out_invalid_nxt_s = 1'b0;
        state_nxt_s       = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      mag_r         <= {MAG_W{1'b0}};
      cnt_r         <= 5'd0;
      left_r        <= 1'b0;
      sticky_r      <= 1'b0;
      sign_r        <= 1'b0;
      out_data_r    <= {OUT_W{1'b0}};
      out_invalid_r <= 1'b0;
      out_inexact_r <= 1'b0;
      out_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      mag_r         <= mag_nxt_s;
      cnt_r         <= cnt_nxt_s;
      left_r        <= left_nxt_s;
      sticky_r      <= sticky_nxt_s;
      sign_r        <= sign_nxt_s;
      out_data_r    <= out_data_nxt_s;
      out_invalid_r <= out_invalid_nxt_s;
      out_inexact_r <= out_inexact_nxt_s;
      out_valid_r   <= (state_nxt_s == DONE);
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_invalid = out_invalid_r;
  assign out_inexact = out_inexact_r;

endmodule

// File: tb/tb_ieee_to_int.sv
// Directed scoreboard bench for ieee_to_int: conversions, latency, backpressure
// and mid-conversion reset.
module tb_ieee_to_int;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        inv;
    logic        inx;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  ieee_to_int #(.OUT_W(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_invalid (out_invalid),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Push the expectation, drive one accept, wait for out_valid and score it.
  task automatic conv(input string tag, input logic [31:0] din, input logic [31:0] ed,
                      input logic ei, input logic ex, input int el);
    exp_t e;
    int   lat;
    logic seen;
    e = '{ed, ei, ex, el};
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_data  = din;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat  = 1;
    seen = out_valid;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      seen = out_valid;
    end
    chk({tag, "_timeout"}, {31'd0, seen}, 32'd1);
    e = sb_q.pop_front();
    chk({tag, "_data"},    out_data,                e.data);
    chk({tag, "_invalid"}, {31'd0, out_invalid},    {31'd0, e.inv});
    chk({tag, "_inexact"}, {31'd0, out_inexact},    {31'd0, e.inx});
    chk({tag, "_latency"}, 32'(lat),                32'(e.lat));
  endtask

  // With out_ready high, the next edge completes the handshake.
  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_out_data",  out_data,             32'd0);
    chk("rst_invalid",   {31'd0, out_invalid}, 32'd0);
    chk("rst_inexact",   {31'd0, out_inexact}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    conv("one",      32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25); handshake("one");
    conv("two23",    32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2);  handshake("two23");
    conv("m123",     32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b1, 19); handshake("m123");
    conv("bigexact", 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9);  handshake("bigexact");
    conv("p2_31",    32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);  handshake("p2_31");
    conv("m2_31",    32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1);  handshake("m2_31");
    conv("nan",      32'h7FC00000, 32'h80000000, 1'b1, 1'b0, 1);  handshake("nan");
    conv("minf",     32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1);  handshake("minf");
    conv("pinf",     32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);  handshake("pinf");
    conv("half",     32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1);  handshake("half");
    conv("zero",     32'h00000000, 32'h00000000, 1'b0, 1'b0, 1);  handshake("zero");
    conv("mdenorm",  32'h80000001, 32'h00000000, 1'b0, 1'b1, 1);  handshake("mdenorm");
    conv("mone",     32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0, 25); handshake("mone");
    conv("mhalf",    32'hBF000000, 32'h00000000, 1'b0, 1'b1, 1);  handshake("mhalf");
    conv("onehalf",  32'h3FC00000, 32'h00000001, 1'b0, 1'b1, 25); handshake("onehalf");
    conv("m2_31m",   32'hCF000001, 32'h80000000, 1'b1, 1'b0, 1);  handshake("m2_31m");

    // Backpressure: result must hold and a second request must be ignored
    out_ready = 1'b0;
    conv("bp", 32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h3F800000;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, out_valid},   32'd1);
      chk("bp_hold_data",  out_data,             32'h00800000);
      chk("bp_hold_inx",   {31'd0, out_inexact}, 32'd0);
      chk("bp_in_ready",   {31'd0, in_ready},    32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    handshake("bp");
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_second", {31'd0, out_valid}, 32'd0);
    chk("bp_idle",      {31'd0, in_ready},  32'd1);

    // Reset in the middle of a shift sequence aborts without output
    @(negedge clk);
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, in_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_data",  out_data,           32'd0);
    @(negedge clk);
    rstn = 1'b1;
    conv("post_rst", 32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25);
    handshake("post_rst");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
